// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters, sync/blank decode and an
// animation frame counter. Every output is registered and is the decode of the
// coordinates it is presented with.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  frame_step,
    output logic [9:0]  hpos,
    output logic [9:0]  vpos,
    output logic        hsync,
    output logic        vsync,
    output logic        display_on,
    output logic        line_start,
    output logic        frame_start,
    output logic [9:0]  frame_count
);

    localparam int unsigned CW       = 10;
    localparam int unsigned EW       = CW + 1;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Coordinates must fit the 10-bit counters.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must be in 1..1024");
    end

    // Decode helpers shared by the reset values and the running datapath.
    function automatic logic in_range(input logic [CW-1:0] p,
                                      input int unsigned  lo,
                                      input int unsigned  hi);
        return ({1'b0, p} >= EW'(lo)) && ({1'b0, p} < EW'(hi));
    endfunction

    function automatic logic sync_lvl(input logic act);
        return act ? SYNC_POL : ~SYNC_POL;
    endfunction

    logic [CW-1:0] hpos_q, hpos_d;
    logic [CW-1:0] vpos_q, vpos_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          disp_q, disp_d;
    logic          lstart_q, lstart_d;
    logic          fstart_q, fstart_d;

    // Next raster position and frame counter update.
    always_comb begin
        hpos_d = hpos_q + CW'(1);
        vpos_d = vpos_q;
        fcnt_d = fcnt_q;
        if (hpos_q == H_LAST) begin
            hpos_d = '0;
            if (vpos_q == V_LAST) begin
                vpos_d = '0;
                fcnt_d = fcnt_q + CW'(frame_step);
            end else begin
                vpos_d = vpos_q + CW'(1);
            end
        end
    end

    // Outputs are decoded from the next coordinates so they register in step.
    always_comb begin
        hsync_d  = sync_lvl(in_range(hpos_d, HS_START, HS_END));
        vsync_d  = sync_lvl(in_range(vpos_d, VS_START, VS_END));
        disp_d   = in_range(hpos_d, 0, H_ACTIVE) && in_range(vpos_d, 0, V_ACTIVE);
        lstart_d = (hpos_d == '0);
        fstart_d = (hpos_d == '0) && (vpos_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos_q   <= '0;
            vpos_q   <= '0;
            fcnt_q   <= '0;
            hsync_q  <= sync_lvl(in_range('0, HS_START, HS_END));
            vsync_q  <= sync_lvl(in_range('0, VS_START, VS_END));
            disp_q   <= in_range('0, 0, H_ACTIVE) && in_range('0, 0, V_ACTIVE);
            lstart_q <= 1'b1;
            fstart_q <= 1'b1;
        end else begin
            hpos_q   <= hpos_d;
            vpos_q   <= vpos_d;
            fcnt_q   <= fcnt_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            disp_q   <= disp_d;
            lstart_q <= lstart_d;
            fstart_q <= fstart_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = disp_q;
    assign line_start  = lstart_q;
    assign frame_start = fstart_q;
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing, a tiny 8x6 raster
// instance for frame timing, frame counter and reset behaviour.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] frame_step;

    logic [9:0] b_hpos, b_vpos, b_fc;
    logic       b_hs, b_vs, b_de, b_ls, b_fs;
    logic [9:0] s_hpos, s_vpos, s_fc;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_big (
        .clk(clk), .rst_n(rst_n), .frame_step(frame_step),
        .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hs), .vsync(b_vs),
        .display_on(b_de), .line_start(b_ls), .frame_start(b_fs),
        .frame_count(b_fc)
    );

    // Tiny raster: H = 4+1+2+1 = 8 (hsync at 5..6), V = 3+1+1+1 = 6 (vsync at 4).
    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .frame_step(frame_step),
        .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hs), .vsync(s_vs),
        .display_on(s_de), .line_start(s_ls), .frame_start(s_fs),
        .frame_count(s_fc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frames(input int n);
        repeat (n * 48) tick();
    endtask

    task automatic run_to_small(input int h, input int v);
        int guard;
        guard = 0;
        while (!(s_hpos == 10'(h) && s_vpos == 10'(v)) && guard < 1000) begin
            tick();
            guard++;
        end
        if (guard >= 1000) chk("run_to_timeout_h", 32'(s_hpos), 32'(h));
    endtask

    // Scan one tiny frame starting at (0,0) and check its timing totals.
    task automatic frame_scan(input string tag);
        int vs_low, vs_min, vs_max, hs_low, de_cnt, ls_cnt, fs_cnt, vs_off_wrap;
        logic prev_vs;
        vs_low = 0; vs_min = 99; vs_max = -1; hs_low = 0; de_cnt = 0;
        ls_cnt = 0; fs_cnt = 0; vs_off_wrap = 0; prev_vs = s_vs;
        for (int i = 0; i < 48; i++) begin
            if (s_vs != prev_vs && s_hpos != 10'd0) vs_off_wrap++;
            prev_vs = s_vs;
            if (!s_vs) begin
                vs_low++;
                if (int'(s_vpos) < vs_min) vs_min = int'(s_vpos);
                if (int'(s_vpos) > vs_max) vs_max = int'(s_vpos);
            end
            if (!s_hs) hs_low++;
            if (s_de) de_cnt++;
            if (s_ls) ls_cnt++;
            if (s_fs) fs_cnt++;
            tick();
        end
        chk({tag, "_vs_low_cycles"}, 32'(vs_low), 32'd8);
        chk({tag, "_vs_first_line"}, 32'(vs_min), 32'd4);
        chk({tag, "_vs_last_line"},  32'(vs_max), 32'd4);
        chk({tag, "_vs_off_wrap"},   32'(vs_off_wrap), 32'd0);
        chk({tag, "_hs_low_cycles"}, 32'(hs_low), 32'd12);
        chk({tag, "_de_cycles"},     32'(de_cnt), 32'd12);
        chk({tag, "_ls_cycles"},     32'(ls_cnt), 32'd6);
        chk({tag, "_fs_per_frame"},  32'(fs_cnt), 32'd1);
        chk({tag, "_period_fs"},     32'(s_fs), 32'd1);
        chk({tag, "_period_h"},      32'(s_hpos), 32'd0);
        chk({tag, "_period_v"},      32'(s_vpos), 32'd0);
    endtask

    initial begin
        int hs_low, hs_first, hs_last, de_drop, vs_low, last_h, last_v;
        logic [9:0] fc0;

        rst_n = 1'b0;
        frame_step = 2'd0;
        repeat (3) tick();

        // Reset state on both instances.
        chk("rst_hpos", 32'(b_hpos), 32'd0);
        chk("rst_vpos", 32'(b_vpos), 32'd0);
        chk("rst_hsync", 32'(b_hs), 32'd1);
        chk("rst_vsync", 32'(b_vs), 32'd1);
        chk("rst_de", 32'(b_de), 32'd1);
        chk("rst_ls", 32'(b_ls), 32'd1);
        chk("rst_fs", 32'(b_fs), 32'd1);
        chk("rst_fc", 32'(b_fc), 32'd0);
        chk("rst_s_hsync", 32'(s_hs), 32'd1);
        chk("rst_s_vsync", 32'(s_vs), 32'd1);

        rst_n = 1'b1;
        tick();
        chk("post_rst_hpos", 32'(b_hpos), 32'd1);
        chk("post_rst_fs", 32'(b_fs), 32'd0);

        // Full-size line: hpos 1..799, then wrap.
        hs_low = 0; hs_first = -1; hs_last = -1; de_drop = -1; vs_low = 0;
        last_h = 0; last_v = 0;
        for (int i = 0; i < 799; i++) begin
            if (!b_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(b_hpos);
                hs_last = int'(b_hpos);
            end
            if (!b_de && de_drop < 0) de_drop = int'(b_hpos);
            if (!b_vs) vs_low++;
            last_h = int'(b_hpos);
            last_v = int'(b_vpos);
            tick();
        end
        chk("line_hs_low_cycles", 32'(hs_low), 32'd96);
        chk("line_hs_first", 32'(hs_first), 32'd656);
        chk("line_hs_last", 32'(hs_last), 32'd751);
        chk("line_de_drop", 32'(de_drop), 32'd640);
        chk("line_vs_low", 32'(vs_low), 32'd0);
        chk("line_last_h", 32'(last_h), 32'd799);
        chk("line_last_v", 32'(last_v), 32'd0);
        chk("wrap_hpos", 32'(b_hpos), 32'd0);
        chk("wrap_vpos", 32'(b_vpos), 32'd1);
        chk("wrap_ls", 32'(b_ls), 32'd1);
        chk("wrap_de", 32'(b_de), 32'd1);
        chk("wrap_fs", 32'(b_fs), 32'd0);

        // Restart the tiny raster and check a whole frame.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        frame_scan("frame");

        // Frame counter: 3x1, 2x2, 1x0.
        frame_step = 2'd1;
        run_frames(3);
        chk("fc_step1_x3", 32'(s_fc), 32'd3);
        frame_step = 2'd2;
        repeat (47) tick();
        chk("fc_before_wrap", 32'(s_fc), 32'd3);
        tick();
        chk("fc_on_fs_edge", 32'(s_fc), 32'd5);
        chk("fc_on_fs_edge_fs", 32'(s_fs), 32'd1);
        run_frames(1);
        chk("fc_step2_x2", 32'(s_fc), 32'd7);
        frame_step = 2'd0;
        run_frames(1);
        chk("fc_step0_hold", 32'(s_fc), 32'd7);

        // Preload to 1023 (7 + 338*3 + 2), then wrap 1023+2 -> 1.
        frame_step = 2'd3;
        run_frames(338);
        frame_step = 2'd2;
        run_frames(1);
        chk("fc_preload", 32'(s_fc), 32'd1023);
        run_frames(1);
        chk("fc_mod_wrap", 32'(s_fc), 32'd1);

        // Mid-frame reset at the tiny analogue of (300,200).
        frame_step = 2'd1;
        run_to_small(3, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_hpos", 32'(s_hpos), 32'd0);
        chk("mid_rst_vpos", 32'(s_vpos), 32'd0);
        chk("mid_rst_fc", 32'(s_fc), 32'd0);
        chk("mid_rst_fs", 32'(s_fs), 32'd1);
        frame_scan("mid_rst");
        chk("mid_rst_fc_after", 32'(s_fc), 32'd1);

        // Step is sampled only on the frame wrap edge.
        fc0 = s_fc;
        for (int i = 0; i < 47; i++) begin
            frame_step = (i % 2 == 0) ? 2'd3 : 2'd0;
            tick();
        end
        chk("samp_mid_hold", 32'(s_fc), 32'(fc0));
        frame_step = 2'd2;
        tick();
        frame_step = 2'd3;
        chk("samp_add2", 32'(s_fc), 32'(fc0) + 32'd2);
        repeat (20) tick();
        chk("samp_after_hold", 32'(s_fc), 32'(fc0) + 32'd2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
